// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control stage: ALUOp/function selectors,
// operation codes and FSM states.
package alu_ctrl_pkg;

    localparam logic [2:0] ALUOP_R_TYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADDI   = 3'b100;
    localparam logic [2:0] ALUOP_ORI    = 3'b101;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;

    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_MUL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    typedef enum logic [3:0] {
        OP_AND     = 4'b0000,
        OP_OR      = 4'b0001,
        OP_NOR     = 4'b0010,
        OP_ADD     = 4'b0011,
        OP_BRANCH  = 4'b0100,
        OP_MUL     = 4'b0101,
        OP_SRL     = 4'b0110,
        OP_SLLV    = 4'b0111,
        OP_ILLEGAL = 4'b1001
    } alu_oper_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD
    } state_e;

endpackage

// File: rtl/alu_control_seq_if.sv
// Handshake bundle between decode/control (master) and the ALU control stage (slave).
interface alu_control_seq_if #(
    parameter int OPER_W    = 4,
    parameter int ILL_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           alu_op;
    logic [5:0]           alu_function;
    logic                 out_valid;
    logic                 out_ready;
    logic [OPER_W-1:0]    alu_operation;
    logic                 alu_busy;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] illegal_count;

    modport master (
        output in_valid, alu_op, alu_function, out_ready,
        input  in_ready, out_valid, alu_operation, alu_busy, illegal, illegal_count
    );

    modport slave (
        input  in_valid, alu_op, alu_function, out_ready,
        output in_ready, out_valid, alu_operation, alu_busy, illegal, illegal_count
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational {ALUOp, funct} -> operation decode.
// ALU_CTRL_SHIFT_EN adds the SRL/SLLV selectors; without it they decode as illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int                OPER_W     = 4,
    parameter logic [OPER_W-1:0] ILLEGAL_OP = OPER_W'(OP_ILLEGAL)
) (
    input  logic [2:0]        alu_op,
    input  logic [5:0]        alu_function,
    output logic [OPER_W-1:0] op,
    output logic              is_multi,
    output logic              illegal
);

    always_comb begin
        op       = ILLEGAL_OP;
        is_multi = 1'b0;
        illegal  = 1'b1;
        case (alu_op)
            ALUOP_R_TYPE: begin
                case (alu_function)
                    FN_AND:  begin op = OPER_W'(OP_AND); illegal = 1'b0; end
                    FN_OR:   begin op = OPER_W'(OP_OR);  illegal = 1'b0; end
                    FN_NOR:  begin op = OPER_W'(OP_NOR); illegal = 1'b0; end
                    FN_ADD:  begin op = OPER_W'(OP_ADD); illegal = 1'b0; end
                    FN_MUL:  begin op = OPER_W'(OP_MUL); illegal = 1'b0; is_multi = 1'b1; end
`ifdef ALU_CTRL_SHIFT_EN
                    FN_SRL:  begin op = OPER_W'(OP_SRL);  illegal = 1'b0; end
                    FN_SLLV: begin op = OPER_W'(OP_SLLV); illegal = 1'b0; end
`endif
                    default: ;
                endcase
            end
            ALUOP_ADDI:   begin op = OPER_W'(OP_ADD);    illegal = 1'b0; end
            ALUOP_ORI:    begin op = OPER_W'(OP_OR);     illegal = 1'b0; end
            ALUOP_BRANCH: begin op = OPER_W'(OP_BRANCH); illegal = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control stage: valid/ready handshake, multi-cycle MUL sequencing,
// saturating illegal-selector counter. Optional shift decode via ALU_CTRL_SHIFT_EN.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int                OPER_W     = 4,
    parameter int                MUL_CYCLES = 4,
    parameter logic [OPER_W-1:0] ILLEGAL_OP = OPER_W'(OP_ILLEGAL),
    parameter int                ILL_CNT_W  = 8
) (
    input logic               clk,
    input logic               reset,
    alu_control_seq_if.slave  bus
);

    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    // BUSY lasts MUL_CYCLES-1 cycles; the counter reaches zero on the last of them.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);

    state_e            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [OPER_W-1:0] dec_op;
    logic              dec_multi;
    logic              dec_ill;
    logic              accept;
    logic              go_busy;

    alu_ctrl_decode #(
        .OPER_W     (OPER_W),
        .ILLEGAL_OP (ILLEGAL_OP)
    ) u_decode (
        .alu_op       (bus.alu_op),
        .alu_function (bus.alu_function),
        .op           (dec_op),
        .is_multi     (dec_multi),
        .illegal      (dec_ill)
    );

    assign accept  = bus.in_valid & bus.in_ready;
    assign go_busy = dec_multi && (MUL_CYCLES > 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = go_busy ? S_BUSY : S_HOLD;
            S_BUSY: if (cnt == '0) state_nx = S_HOLD;
            S_HOLD: if (bus.out_ready) state_nx = accept ? (go_busy ? S_BUSY : S_HOLD) : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.alu_busy  = 1'b0;
        case (state)
            S_IDLE: bus.in_ready = 1'b1;
            S_BUSY: bus.alu_busy = 1'b1;
            S_HOLD: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.alu_operation <= ILLEGAL_OP;
            bus.illegal       <= 1'b0;
            bus.illegal_count <= '0;
            cnt               <= '0;
        end else if (accept) begin
            bus.alu_operation <= dec_op;
            bus.illegal       <= dec_ill;
            cnt               <= go_busy ? CNT_LOAD : '0;
            if (dec_ill && (bus.illegal_count != '1))
                bus.illegal_count <= bus.illegal_count + ILL_CNT_W'(1);
        end else if ((state == S_BUSY) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: directed scenarios plus random traffic, checked every cycle
// against a latency/queue model. Honours ALU_CTRL_SHIFT_EN for the shift selectors.
module tb_alu_control_seq;

    localparam int MC = 4;

    logic clk;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   checking = 0;

    alu_control_seq_if #(.OPER_W(4), .ILL_CNT_W(8)) b0 ();
    alu_control_seq_if #(.OPER_W(4), .ILL_CNT_W(8)) b1 ();

    alu_control_seq #(.OPER_W(4), .MUL_CYCLES(MC), .ILLEGAL_OP(4'b1001), .ILL_CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave)
    );
    alu_control_seq #(.OPER_W(4), .MUL_CYCLES(1), .ILLEGAL_OP(4'b1001), .ILL_CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );

    assign b1.in_valid     = b0.in_valid;
    assign b1.alu_op       = b0.alu_op;
    assign b1.alu_function = b0.alu_function;
    assign b1.out_ready    = b0.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the selector table.
    function automatic void ref_decode(input logic [2:0] a, input logic [5:0] f,
                                       output int op, output bit ill, output bit multi);
        op = 9; ill = 1; multi = 0;
        if (a == 3'b100)      begin op = 3; ill = 0; end
        else if (a == 3'b101) begin op = 1; ill = 0; end
        else if (a == 3'b001) begin op = 4; ill = 0; end
        else if (a == 3'b111) begin
            if (f == 6'b100100)      begin op = 0; ill = 0; end
            else if (f == 6'b100101) begin op = 1; ill = 0; end
            else if (f == 6'b100111) begin op = 2; ill = 0; end
            else if (f == 6'b100000) begin op = 3; ill = 0; end
            else if (f == 6'b000000) begin op = 5; ill = 0; multi = 1; end
`ifdef ALU_CTRL_SHIFT_EN
            else if (f == 6'b000010) begin op = 6; ill = 0; end
            else if (f == 6'b000100) begin op = 7; ill = 0; end
`endif
        end
    endfunction

    // Model: at most one item in the stage, with a countdown until it is presented.
    bit has_item  = 0;
    int wait_left = 0;
    int m_op      = 9;
    bit m_ill     = 0;
    int m_cnt     = 0;

    function automatic bit model_ready(input bit ordy);
        return !has_item || (wait_left == 0 && ordy);
    endfunction

    always @(posedge clk or posedge reset) begin
        int op; bit ill; bit multi; bit acc;
        if (reset) begin
            has_item = 0; wait_left = 0; m_op = 9; m_ill = 0; m_cnt = 0;
        end else begin
            acc = b0.in_valid && model_ready(b0.out_ready);
            if (has_item && wait_left > 0) wait_left--;
            else if (has_item && b0.out_ready) has_item = 0;
            if (acc) begin
                ref_decode(b0.alu_op, b0.alu_function, op, ill, multi);
                has_item  = 1;
                wait_left = multi ? MC - 1 : 0;
                m_op      = op;
                m_ill     = ill;
                if (ill) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("out_valid", 32'(b0.out_valid), 32'(has_item && wait_left == 0));
            chk("alu_busy",  32'(b0.alu_busy),  32'(has_item && wait_left > 0));
            chk("in_ready",  32'(b0.in_ready),  32'(model_ready(b0.out_ready)));
            chk("alu_operation", 32'(b0.alu_operation), 32'(m_op));
            chk("illegal",   32'(b0.illegal),   32'(m_ill));
            chk("illegal_count", 32'(b0.illegal_count), 32'((m_cnt > 255) ? 255 : m_cnt));
        end
    end

    task automatic drive(input bit v, input logic [2:0] a, input logic [5:0] f, input bit ordy);
        @(posedge clk);
        #1;
        b0.in_valid     = v;
        b0.alu_op       = a;
        b0.alu_function = f;
        b0.out_ready    = ordy;
    endtask

    logic [8:0] sel_tab [12] = '{9'b111_100100, 9'b111_100101, 9'b111_100111, 9'b111_100000,
                                 9'b111_000000, 9'b100_011011, 9'b101_110001, 9'b001_000111,
                                 9'b111_111111, 9'b111_000010, 9'b111_000100, 9'b010_100000};

    initial begin
        logic [8:0] sel;
        reset = 1'b1;
        b0.in_valid = 0; b0.alu_op = '0; b0.alu_function = '0; b0.out_ready = 1;
        repeat (2) @(posedge clk);
        checking = 1;
        @(negedge clk);
        chk("reset_op", 32'(b0.alu_operation), 32'h9);
        chk("reset_valid", 32'(b0.out_valid), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // ADD, single-cycle latency
        drive(1, 3'b111, 6'b100000, 1);
        drive(0, 3'b000, 6'b000000, 1);
        @(negedge clk);
        chk("add_valid", 32'(b0.out_valid), 32'h1);
        chk("add_op", 32'(b0.alu_operation), 32'h3);
        chk("add_ill", 32'(b0.illegal), 32'h0);
        drive(0, 3'b000, 6'b000000, 1);

        // back-to-back AND, OR, ORI
        drive(1, 3'b111, 6'b100100, 1);
        drive(1, 3'b111, 6'b100101, 1);
        @(negedge clk);
        chk("b2b_and", 32'(b0.alu_operation), 32'h0);
        chk("b2b_rdy0", 32'(b0.in_ready), 32'h1);
        drive(1, 3'b101, 6'b010101, 1);
        @(negedge clk);
        chk("b2b_or", 32'(b0.alu_operation), 32'h1);
        chk("b2b_rdy1", 32'(b0.in_ready), 32'h1);
        drive(0, 3'b000, 6'b000000, 1);
        @(negedge clk);
        chk("b2b_ori", 32'(b0.alu_operation), 32'h1);
        chk("b2b_valid", 32'(b0.out_valid), 32'h1);
        drive(0, 3'b000, 6'b000000, 1);

        // MUL: 3 busy cycles at MUL_CYCLES=4, single-cycle at MUL_CYCLES=1
        drive(1, 3'b111, 6'b000000, 1);
        drive(0, 3'b000, 6'b000000, 1);
        @(negedge clk);
        chk("mul1_valid", 32'(b1.out_valid), 32'h1);
        chk("mul1_busy", 32'(b1.alu_busy), 32'h0);
        chk("mul1_op", 32'(b1.alu_operation), 32'h5);
        chk("mul_busy0", 32'(b0.alu_busy), 32'h1);
        chk("mul_rdy0", 32'(b0.in_ready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 3'b111, 6'b100000, 1);
            @(negedge clk);
            chk("mul_busy", 32'(b0.alu_busy), 32'h1);
            chk("mul_rdy", 32'(b0.in_ready), 32'h0);
        end
        drive(0, 3'b000, 6'b000000, 1);
        @(negedge clk);
        chk("mul_valid", 32'(b0.out_valid), 32'h1);
        chk("mul_op", 32'(b0.alu_operation), 32'h5);
        drive(0, 3'b000, 6'b000000, 1);

        // BEQ held under back-pressure
        drive(1, 3'b001, 6'b101010, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'b111, 6'b100000, 0);
            @(negedge clk);
            chk("hold_op", 32'(b0.alu_operation), 32'h4);
            chk("hold_rdy", 32'(b0.in_ready), 32'h0);
        end
        drive(1, 3'b111, 6'b100000, 1);
        drive(0, 3'b000, 6'b000000, 1);
        @(negedge clk);
        chk("after_hold_op", 32'(b0.alu_operation), 32'h3);
        drive(0, 3'b000, 6'b000000, 1);

        // illegal saturation
        for (int i = 0; i < 300; i++) drive(1, 3'b111, 6'b111111, 1);
        drive(0, 3'b000, 6'b000000, 1);
        @(negedge clk);
        chk("sat_count", 32'(b0.illegal_count), 32'd255);
        chk("sat_ill", 32'(b0.illegal), 32'h1);
        chk("sat_op", 32'(b0.alu_operation), 32'h9);
        drive(1, 3'b111, 6'b000010, 1);
        drive(0, 3'b000, 6'b000000, 1);
        @(negedge clk);
`ifdef ALU_CTRL_SHIFT_EN
        chk("srl_op", 32'(b0.alu_operation), 32'h6);
        chk("srl_ill", 32'(b0.illegal), 32'h0);
`else
        chk("srl_op", 32'(b0.alu_operation), 32'h9);
        chk("srl_ill", 32'(b0.illegal), 32'h1);
`endif
        drive(0, 3'b000, 6'b000000, 1);

        // reset in the middle of a MUL
        drive(1, 3'b111, 6'b000000, 1);
        drive(0, 3'b000, 6'b000000, 1);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("rst_valid", 32'(b0.out_valid), 32'h0);
        chk("rst_busy", 32'(b0.alu_busy), 32'h0);
        chk("rst_op", 32'(b0.alu_operation), 32'h9);
        @(posedge clk); #1 reset = 1'b0;
        drive(1, 3'b111, 6'b100000, 1);
        drive(0, 3'b000, 6'b000000, 1);
        @(negedge clk);
        chk("post_rst_valid", 32'(b0.out_valid), 32'h1);
        chk("post_rst_op", 32'(b0.alu_operation), 32'h3);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            sel = ($urandom_range(0, 3) == 0) ? 9'($urandom) : sel_tab[$urandom_range(0, 11)];
            b0.in_valid     = ($urandom_range(0, 9) < 7);
            b0.alu_op       = sel[8:6];
            b0.alu_function = sel[5:0];
            b0.out_ready    = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
